// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sweep controller: state encoding, default
// widths and the minimum legal amplitude divisor.
package awg_pkg;

    localparam int FW_DEF  = 12;
    localparam int DW_DEF  = 16;
    localparam int AW_DEF  = 3;
    localparam int AMP_MIN = 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN_UP = 2'd1;
    localparam logic [1:0] ST_RUN_DN = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_RUN_UP = ST_RUN_UP,
        S_RUN_DN = ST_RUN_DN,
        S_DONE   = ST_DONE
    } state_e;

endpackage

// File: rtl/awg_dwell_timer.sv
// Loadable down-counter that times how long each sweep step is held.
// expire is high while the count sits at zero.
module awg_dwell_timer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [DW-1:0] load_val,
    output logic          expire
);

    logic [DW-1:0] count_q;
    logic [DW-1:0] count_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {DW{1'b0}})) begin
            count_d = count_q - {{(DW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {DW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == {DW{1'b0}});

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Frequency-sweep scheduler feeding one AWG generator. Steps the tuning word
// from f_start to f_stop (inclusive) by f_step, holding each value dwell+1
// clocks. Optional macro SWEEP_BIDIR_EN adds a downward leg after the upward one.
module awg_sweep_ctrl
    import awg_pkg::*;
#(
    parameter int FW = FW_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [FW-1:0] cfg_f_start,
    input  logic [FW-1:0] cfg_f_stop,
    input  logic [FW-1:0] cfg_f_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [AW-1:0] cfg_amp,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          abort,
    output logic          gen_en,
    output logic [FW-1:0] gen_freq,
    output logic [AW-1:0] gen_amp,
    output logic          busy,
    output logic          step_tick,
    output logic          done
);

    state_e        state_q, state_d;
    logic [FW-1:0] f_start_q, f_start_d;
    logic [FW-1:0] f_stop_q, f_stop_d;
    logic [FW-1:0] f_step_q, f_step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [AW-1:0] amp_q, amp_d;
    logic          loop_q, loop_d;
    logic          gen_en_q, gen_en_d;
    logic [FW-1:0] gen_freq_q, gen_freq_d;
    logic [AW-1:0] gen_amp_q, gen_amp_d;
    logic          busy_q, busy_d;
    logic          step_tick_q, step_tick_d;
    logic          done_q, done_d;
    logic          cfg_ready_q, cfg_ready_d;

    logic          tmr_load_s;
    logic          tmr_dec_s;
    logic          tmr_expire_s;
    logic          end_sweep_s;
    logic [FW:0]   nxt_up_s;
`ifdef SWEEP_BIDIR_EN
    logic signed [FW:0] nxt_dn_s;
`endif

    awg_dwell_timer #(.DW(DW)) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .dec      (tmr_dec_s),
        .load_val (dwell_d),
        .expire   (tmr_expire_s)
    );

    // Config capture, sweep FSM and frequency stepping; abort overrides last.
    always_comb begin
        state_d     = state_q;
        f_start_d   = f_start_q;
        f_stop_d    = f_stop_q;
        f_step_d    = f_step_q;
        dwell_d     = dwell_q;
        amp_d       = amp_q;
        loop_d      = loop_q;
        gen_en_d    = gen_en_q;
        gen_freq_d  = gen_freq_q;
        gen_amp_d   = gen_amp_q;
        step_tick_d = 1'b0;
        done_d      = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_dec_s   = 1'b0;
        end_sweep_s = 1'b0;
        // Carry-out lands in the top bit, so overflow always compares as past stop.
        nxt_up_s    = {1'b0, gen_freq_q} + {1'b0, f_step_q};
`ifdef SWEEP_BIDIR_EN
        nxt_dn_s    = $signed({1'b0, gen_freq_q}) - $signed({1'b0, f_step_q});
`endif

        // Config is only taken in IDLE; a zero divisor would stall the generator.
        if (cfg_valid && (state_q == S_IDLE)) begin
            f_start_d = cfg_f_start;
            f_stop_d  = cfg_f_stop;
            f_step_d  = cfg_f_step;
            dwell_d   = cfg_dwell;
            amp_d     = (cfg_amp == {AW{1'b0}}) ? AW'(AMP_MIN) : cfg_amp;
            loop_d    = cfg_loop;
        end else begin
            f_start_d = f_start_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN_UP;
                    gen_en_d   = 1'b1;
                    gen_freq_d = f_start_d;
                    gen_amp_d  = amp_d;
                    tmr_load_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN_UP: begin
                if (!tmr_expire_s) begin
                    tmr_dec_s = 1'b1;
                end else if (nxt_up_s > {1'b0, f_stop_q}) begin
`ifdef SWEEP_BIDIR_EN
                    state_d    = S_RUN_DN;
                    tmr_load_s = 1'b1;
`else
                    end_sweep_s = 1'b1;
`endif
                end else begin
                    gen_freq_d  = nxt_up_s[FW-1:0];
                    step_tick_d = 1'b1;
                    tmr_load_s  = 1'b1;
                end
            end
`ifdef SWEEP_BIDIR_EN
            S_RUN_DN: begin
                if (!tmr_expire_s) begin
                    tmr_dec_s = 1'b1;
                end else if (nxt_dn_s < $signed({1'b0, f_start_q})) begin
                    end_sweep_s = 1'b1;
                end else begin
                    gen_freq_d  = nxt_dn_s[FW-1:0];
                    step_tick_d = 1'b1;
                    tmr_load_s  = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                gen_en_d   = 1'b0;
                gen_freq_d = {FW{1'b0}};
            end
        endcase

        // Shared end-of-sweep handling: restart when looping, else finish.
        if (end_sweep_s) begin
            if (loop_q) begin
                state_d    = S_RUN_UP;
                gen_freq_d = f_start_q;
                tmr_load_s = 1'b1;
            end else begin
                state_d    = S_DONE;
                gen_en_d   = 1'b0;
                gen_freq_d = {FW{1'b0}};
                done_d     = 1'b1;
            end
        end else begin
            done_d = done_d;
        end

        // Abort beats everything, including a start in the same cycle.
        if (abort) begin
            state_d     = S_IDLE;
            gen_en_d    = 1'b0;
            gen_freq_d  = {FW{1'b0}};
            step_tick_d = 1'b0;
            done_d      = 1'b0;
            tmr_load_s  = 1'b0;
            tmr_dec_s   = 1'b0;
        end else begin
            state_d = state_d;
        end

        busy_d      = (state_d != S_IDLE);
        cfg_ready_d = (state_d == S_IDLE);
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            f_start_q   <= {FW{1'b0}};
            f_stop_q    <= {FW{1'b0}};
            f_step_q    <= {{(FW-1){1'b0}}, 1'b1};
            dwell_q     <= {DW{1'b0}};
            amp_q       <= AW'(AMP_MIN);
            loop_q      <= 1'b0;
            gen_en_q    <= 1'b0;
            gen_freq_q  <= {FW{1'b0}};
            gen_amp_q   <= AW'(AMP_MIN);
            busy_q      <= 1'b0;
            step_tick_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            f_start_q   <= f_start_d;
            f_stop_q    <= f_stop_d;
            f_step_q    <= f_step_d;
            dwell_q     <= dwell_d;
            amp_q       <= amp_d;
            loop_q      <= loop_d;
            gen_en_q    <= gen_en_d;
            gen_freq_q  <= gen_freq_d;
            gen_amp_q   <= gen_amp_d;
            busy_q      <= busy_d;
            step_tick_q <= step_tick_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign gen_en    = gen_en_q;
    assign gen_freq  = gen_freq_q;
    assign gen_amp   = gen_amp_q;
    assign busy      = busy_q;
    assign step_tick = step_tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Directed bench for awg_sweep_ctrl. Expected values are hand-derived; BIDIR
// shifts end-of-sweep positions when SWEEP_BIDIR_EN is defined.
module tb_awg_sweep_ctrl;

`ifdef SWEEP_BIDIR_EN
    localparam int BIDIR = 1;
`else
    localparam int BIDIR = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_f_start;
    logic [11:0] cfg_f_stop;
    logic [11:0] cfg_f_step;
    logic [15:0] cfg_dwell;
    logic [2:0]  cfg_amp;
    logic        cfg_loop;
    logic        start;
    logic        abort;
    logic        gen_en;
    logic [11:0] gen_freq;
    logic [2:0]  gen_amp;
    logic        busy;
    logic        step_tick;
    logic        done;

    int n_total = 0;
    int n_bad   = 0;

    logic [11:0] fr_a   [1:64];
    logic        en_a   [1:64];
    logic        done_a [1:64];
    logic        tick_a [1:64];

    awg_sweep_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_f_start (cfg_f_start),
        .cfg_f_stop  (cfg_f_stop),
        .cfg_f_step  (cfg_f_step),
        .cfg_dwell   (cfg_dwell),
        .cfg_amp     (cfg_amp),
        .cfg_loop    (cfg_loop),
        .start       (start),
        .abort       (abort),
        .gen_en      (gen_en),
        .gen_freq    (gen_freq),
        .gen_amp     (gen_amp),
        .busy        (busy),
        .step_tick   (step_tick),
        .done        (done)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic [11:0] fs, input logic [11:0] fe, input logic [11:0] st,
                           input logic [15:0] dw, input logic [2:0] am, input logic lp);
        cfg_f_start = fs;
        cfg_f_stop  = fe;
        cfg_f_step  = st;
        cfg_dwell   = dw;
        cfg_amp     = am;
        cfg_loop    = lp;
    endtask

    task automatic load_cfg(input logic [11:0] fs, input logic [11:0] fe, input logic [11:0] st,
                            input logic [15:0] dw, input logic [2:0] am, input logic lp);
        set_cfg(fs, fe, st, dw, am, lp);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Pulse start at the current negedge and record n following negedge samples.
    task automatic run_capture(input int n);
        start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            start       = 1'b0;
            cfg_valid   = 1'b0;
            fr_a[k]     = gen_freq;
            en_a[k]     = gen_en;
            done_a[k]   = done;
            tick_a[k]   = step_tick;
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        int nd;
        int nt;
        int nbad_cyc;
        int dk;
        logic [11:0] ef;

        rst_n = 1'b0;
        cfg_valid = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(12'h000, 12'h000, 12'h000, 16'd0, 3'd0, 1'b0);
        @(negedge clk);
        check_eq("rst_gen_en", {31'd0, gen_en}, 32'd0);
        check_eq("rst_gen_freq", {20'd0, gen_freq}, 32'd0);
        check_eq("rst_gen_amp", {29'd0, gen_amp}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done_tick", {30'd0, done, step_tick}, 32'd0);
        check_eq("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: basic up sweep 0x010..0x040, dwell 3.
        load_cfg(12'h010, 12'h040, 12'h010, 16'd3, 3'd5, 1'b0);
        run_capture(18 + 16 * BIDIR);
        dk = 17 + 16 * BIDIR;
        nbad_cyc = 0;
        nd = 0;
        nt = 0;
        for (int k = 1; k < dk; k++) begin
            if (k <= 16) ef = 12'h010 + 12'(((k - 1) / 4) * 16);
            else         ef = 12'h040 - 12'(((k - 17) / 4) * 16);
            if (fr_a[k] !== ef || en_a[k] !== 1'b1) nbad_cyc++;
        end
        for (int k = 1; k <= 18 + 16 * BIDIR; k++) begin
            nd += int'(done_a[k]);
            nt += int'(tick_a[k]);
        end
        check_eq("t1_k1_freq", {20'd0, fr_a[1]}, 32'h010);
        check_eq("t1_k5_freq", {20'd0, fr_a[5]}, 32'h020);
        check_eq("t1_k16_freq", {20'd0, fr_a[16]}, 32'h040);
        check_eq("t1_step_seq", nbad_cyc, 0);
        check_eq("t1_done_pos", {31'd0, done_a[dk]}, 32'd1);
        check_eq("t1_done_freq", {19'd0, en_a[dk], fr_a[dk]}, 32'd0);
        check_eq("t1_done_cnt", nd, 1);
        check_eq("t1_tick_cnt", nt, 3 + 3 * BIDIR);
        check_eq("t1_idle_busy", {31'd0, busy}, 32'd0);

        // Test 1b: amplitude forwarded; cfg held during run is refused and ignored.
        run_capture(2);
        check_eq("t1_amp", {29'd0, gen_amp}, 32'd5);
        set_cfg(12'h300, 12'h400, 12'h001, 16'd0, 3'd2, 1'b1);
        cfg_valid = 1'b1;
        nbad_cyc = 0;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            if (cfg_ready !== 1'b0) nbad_cyc++;
        end
        cfg_valid = 1'b0;
        check_eq("t5_ready_low", nbad_cyc, 0);
        check_eq("t5_freq_kept", {20'd0, gen_freq}, 32'h020);
        do_abort();
        run_capture(1);
        check_eq("t5_cfg_kept", {17'd0, gen_amp, gen_freq}, {17'd0, 3'd5, 12'h010});
        do_abort();

        // Test 2: loop restarts without done; abort drops enable next cycle.
        load_cfg(12'h010, 12'h040, 12'h010, 16'd3, 3'd1, 1'b1);
        run_capture(17);
        nd = 0;
        for (int k = 1; k <= 17; k++) nd += int'(done_a[k]);
        check_eq("t2_wrap_freq", {20'd0, fr_a[17]}, 32'(BIDIR != 0 ? 12'h040 : 12'h010));
        check_eq("t2_wrap_en", {31'd0, en_a[17]}, 32'd1);
        check_eq("t2_no_done", nd, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t2_abort", {18'd0, busy, done, gen_en, gen_freq}, 32'd0);
        @(negedge clk);
        check_eq("t2_abort_nodone", {31'd0, done}, 32'd0);

        // Test 3: overflow never wraps to a low tuning word.
        load_cfg(12'hFF0, 12'hFFF, 12'h020, 16'd3, 3'd1, 1'b0);
        run_capture(12);
        nbad_cyc = 0;
        nd = 0;
        for (int k = 1; k <= 12; k++) begin
            if (fr_a[k] == 12'h010) nbad_cyc++;
            nd += int'(done_a[k]);
        end
        check_eq("t3_k4_freq", {20'd0, fr_a[4]}, 32'hFF0);
        check_eq("t3_done_pos", {31'd0, done_a[5 + 4 * BIDIR]}, 32'd1);
        check_eq("t3_no_wrap", nbad_cyc, 0);
        check_eq("t3_done_cnt", nd, 1);

        // Test 4a: zero amplitude and zero step hold f_start indefinitely.
        load_cfg(12'h010, 12'h040, 12'h000, 16'd0, 3'd0, 1'b0);
        start = 1'b1;
        nbad_cyc = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (gen_freq !== 12'h010 || gen_en !== 1'b1 || done !== 1'b0) nbad_cyc++;
        end
        check_eq("t4_amp_zero", {29'd0, gen_amp}, 32'd1);
        check_eq("t4_step_zero", nbad_cyc, 0);
        do_abort();

        // Test 4b: start above stop gives one dwell then done.
        load_cfg(12'h050, 12'h040, 12'h010, 16'd1, 3'd3, 1'b0);
        run_capture(4 + 2 * BIDIR);
        check_eq("t4_rev_freq", {20'd0, fr_a[2]}, 32'h050);
        check_eq("t4_rev_done", {31'd0, done_a[3 + 2 * BIDIR]}, 32'd1);

        // Test 5: valid and start together use the new config.
        set_cfg(12'h100, 12'h100, 12'h001, 16'd0, 3'd2, 1'b0);
        cfg_valid = 1'b1;
        run_capture(3 + BIDIR);
        check_eq("t5_same_cycle", {17'd0, gen_amp, fr_a[1]}, {17'd0, 3'd2, 12'h100});
        check_eq("t5_sc_done", {31'd0, done_a[2 + BIDIR]}, 32'd1);

        // Test 6: asynchronous reset mid-sweep, then config back at defaults.
        load_cfg(12'h010, 12'h040, 12'h010, 16'd3, 3'd6, 1'b0);
        run_capture(6);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_rst", {14'd0, cfg_ready, busy, done, step_tick, gen_en, gen_amp, gen_freq},
                 {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 12'h000});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_capture(3 + BIDIR);
        check_eq("t6_cfg_lost", {16'd0, en_a[1], gen_amp, fr_a[1]}, {16'd0, 1'b1, 3'd1, 12'h000});
        check_eq("t6_done", {31'd0, done_a[2 + BIDIR]}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
